// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus: requester handshakes, decode scoreboard query, and the
// register-file write port.
interface regfile_wb_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int XLEN  = 32
);
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ*5-1:0]    req_rd;
  logic [N_REQ*XLEN-1:0] req_data;
  logic                  issue_valid;
  logic [4:0]            issue_rd;
  logic [4:0]            rs1_addr;
  logic [4:0]            rs2_addr;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  we3;
  logic [4:0]            a3;
  logic [XLEN-1:0]       wd3;
  logic                  wb_unexpected;

  modport master (
    output req_valid, req_rd, req_data, issue_valid, issue_rd, rs1_addr, rs2_addr,
    input  req_ready, rs1_busy, rs2_busy, we3, a3, wd3, wb_unexpected
  );

  modport slave (
    input  req_valid, req_rd, req_data, issue_valid, issue_rd, rs1_addr, rs2_addr,
    output req_ready, rs1_busy, rs2_busy, we3, a3, wd3, wb_unexpected
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the register file write port among N_REQ writeback
// requesters, plus a pending-write scoreboard for decode RAW stalls.
module regfile_wb_arbiter #(
  parameter int N_REQ = 2,
  parameter int XLEN  = 32
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]    r_ptr;
  logic [31:0]      r_pending;
  logic             r_we3;
  logic [4:0]       r_a3;
  logic [XLEN-1:0]  r_wd3;
  logic             r_unexp;

  logic             w_any;
  logic [PW-1:0]    w_gidx;
  logic [PW-1:0]    w_ptr_nxt;
  logic [N_REQ-1:0] w_ready;
  logic [4:0]       w_rd;
  logic [XLEN-1:0]  w_data;
  logic [31:0]      w_pend_nxt;

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    w_any  = 1'b0;
    w_gidx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_any && bus.req_valid[(int'(r_ptr) + k) % N_REQ]) begin
        w_any  = 1'b1;
        w_gidx = PW'((int'(r_ptr) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    w_ready = '0;
    for (int i = 0; i < N_REQ; i++)
      w_ready[i] = !rst && w_any && (w_gidx == PW'(i));
  end

  assign w_rd      = bus.req_rd[int'(w_gidx)*5 +: 5];
  assign w_data    = bus.req_data[int'(w_gidx)*XLEN +: XLEN];
  assign w_ptr_nxt = (int'(w_gidx) == N_REQ - 1) ? '0 : w_gidx + 1'b1;

  // Clear for the committing write first, so a same-edge issue of that reg wins.
  always_comb begin
    w_pend_nxt = r_pending;
    if (r_we3)
      w_pend_nxt[r_a3] = 1'b0;
    if (bus.issue_valid && bus.issue_rd != 5'd0)
      w_pend_nxt[bus.issue_rd] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_pending <= '0;
      r_we3     <= 1'b0;
      r_a3      <= '0;
      r_wd3     <= '0;
      r_unexp   <= 1'b0;
    end else begin
      r_pending <= w_pend_nxt;
      r_unexp   <= r_we3 && !r_pending[r_a3];
      if (w_any) begin
        r_ptr <= w_ptr_nxt;
        r_we3 <= (w_rd != 5'd0);
        r_a3  <= w_rd;
        r_wd3 <= w_data;
      end else begin
        r_we3 <= 1'b0;
      end
    end
  end

  assign bus.req_ready     = w_ready;
  assign bus.rs1_busy      = (bus.rs1_addr != 5'd0) && r_pending[bus.rs1_addr];
  assign bus.rs2_busy      = (bus.rs2_addr != 5'd0) && r_pending[bus.rs2_addr];
  assign bus.we3           = r_we3;
  assign bus.a3            = r_a3;
  assign bus.wd3           = r_wd3;
  assign bus.wb_unexpected = r_unexp;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios then randomized traffic, all checked against a
// cycle-level reference model of the arbiter and scoreboard.
module tb_regfile_wb_arbiter;
  localparam int N    = 2;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.N_REQ(N), .XLEN(XLEN)) bus();
  regfile_wb_arbiter #(.N_REQ(N), .XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int errors = 0;

  // requester-side state
  bit              v   [N];
  logic [4:0]      rd  [N];
  logic [XLEN-1:0] dat [N];

  // reference model
  int              m_ptr;
  bit              m_pend [32];
  bit              m_we3;
  logic [4:0]      m_a3;
  logic [XLEN-1:0] m_wd3;
  bit              m_unexp;
  int              m_g;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int arb();
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]           = v[i];
      bus.req_rd[5*i +: 5]       = rd[i];
      bus.req_data[XLEN*i +: XLEN] = dat[i];
    end
  endtask

  task automatic check_outs();
    logic [N-1:0] er;
    er  = '0;
    m_g = rst ? -1 : arb();
    if (m_g >= 0) er[m_g] = 1'b1;
    chk("ready",    bus.req_ready, er);
    chk("rs1_busy", bus.rs1_busy, (bus.rs1_addr != 0) && m_pend[bus.rs1_addr]);
    chk("rs2_busy", bus.rs2_busy, (bus.rs2_addr != 0) && m_pend[bus.rs2_addr]);
    chk("we3",      bus.we3, m_we3);
    chk("a3",       bus.a3, m_a3);
    chk("wd3",      bus.wd3, m_wd3);
    chk("unexp",    bus.wb_unexpected, m_unexp);
  endtask

  task automatic model_update();
    bit nu;
    if (rst) begin
      m_ptr = 0; m_we3 = 0; m_a3 = '0; m_wd3 = '0; m_unexp = 0;
      for (int r = 0; r < 32; r++) m_pend[r] = 0;
    end else begin
      nu = m_we3 && !m_pend[m_a3];
      if (m_we3) m_pend[m_a3] = 0;
      if (bus.issue_valid && bus.issue_rd != 0) m_pend[bus.issue_rd] = 1;
      if (m_g >= 0) begin
        m_we3 = (rd[m_g] != 0);
        m_a3  = rd[m_g];
        m_wd3 = dat[m_g];
        m_ptr = (m_g + 1) % N;
      end else begin
        m_we3 = 0;
      end
      m_unexp = nu;
    end
  endtask

  // Inputs are set at negedge; outputs checked just after, model steps at posedge.
  task automatic tick();
    drive();
    #1 check_outs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < N; i++) begin v[i] = 0; rd[i] = '0; dat[i] = '0; end
    bus.issue_valid = 0; bus.issue_rd = '0; bus.rs1_addr = '0; bus.rs2_addr = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < N; i++) begin v[i] = 1; rd[i] = 5'(i + 1); end
    drive();
    m_g = -1;
    @(posedge clk);
    model_update();
    @(negedge clk);

    // T1: reset holds ready low even with all requesters valid
    bus.rs1_addr = 5'd1; bus.rs2_addr = 5'd2;
    repeat (2) tick();
    rst = 1'b0;
    idle_inputs();

    // T2: single write of a pending register
    bus.issue_valid = 1; bus.issue_rd = 5'd5; bus.rs1_addr = 5'd5;
    tick();
    bus.issue_valid = 0;
    v[0] = 1; rd[0] = 5'd5; dat[0] = 32'hDEADBEEF;
    tick();
    v[0] = 0;
    tick();
    chk("t2_busy_cleared", bus.rs1_busy, 1'b0);
    tick();

    // T3: contention with distinct destinations
    v[0] = 1; v[1] = 1; rd[0] = 5'd10; rd[1] = 5'd11;
    for (int k = 0; k < 4; k++) begin
      dat[0] = $urandom; dat[1] = $urandom;
      tick();
    end
    v[0] = 0; v[1] = 0;
    tick();

    // T4: x0 write is accepted and dropped
    v[1] = 1; rd[1] = 5'd0; dat[1] = 32'h1234;
    tick();
    v[1] = 0;
    tick();
    chk("t4_we3", bus.we3, 1'b0);

    // T5: commit and re-issue of r7 on the same edge
    bus.issue_valid = 1; bus.issue_rd = 5'd7; bus.rs1_addr = 5'd7;
    tick();
    bus.issue_valid = 0; v[0] = 1; rd[0] = 5'd7; dat[0] = 32'h77;
    tick();
    v[0] = 0; bus.issue_valid = 1;
    tick();
    bus.issue_valid = 0;
    tick();
    chk("t5_set_wins", bus.rs1_busy, 1'b1);
    v[0] = 1;
    tick();
    v[0] = 0;
    repeat (2) tick();
    chk("t5_cleared", bus.rs1_busy, 1'b0);

    // T6: reset the cycle after a transfer
    bus.issue_valid = 1; bus.issue_rd = 5'd9; bus.rs1_addr = 5'd9;
    tick();
    bus.issue_valid = 0; v[0] = 1; rd[0] = 5'd9; dat[0] = 32'h99;
    tick();
    v[0] = 0; rst = 1;
    tick();
    rst = 0;
    tick();
    chk("t6_we3", bus.we3, 1'b0);
    chk("t6_busy", bus.rs1_busy, 1'b0);

    // randomized traffic; granted requesters may re-present, others hold
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] || i == m_g) begin
          v[i]   = ($urandom_range(0, 3) != 0);
          rd[i]  = 5'($urandom_range(0, 7));
          dat[i] = $urandom;
        end
      end
      bus.issue_valid = $urandom_range(0, 1);
      bus.issue_rd    = 5'($urandom_range(0, 7));
      bus.rs1_addr    = 5'($urandom_range(0, 7));
      bus.rs2_addr    = 5'($urandom_range(0, 7));
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
